// File: rtl/cycle_seq_pkg.sv
// Shared definitions for the cycle sequencer: sequencer states and the
// parameter-legality checks that the top level evaluates at elaboration.
package cycle_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  function automatic bit div_ratio_ok(int unsigned div_ratio);
    return div_ratio >= 2;
  endfunction

  function automatic bit rst_hold_ok(int unsigned rst_hold);
    return rst_hold >= 1;
  endfunction

  // The run limit must be representable in the cycle counter.
  function automatic bit max_cycles_ok(int unsigned cyc_w, longint unsigned max_cycles);
    if (cyc_w >= 63) return 1'b1;
    return max_cycles < (64'd1 << cyc_w);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Modulo-DIV_RATIO phase counter.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (phase <= 0)
//   clr   - synchronous clear (phase <= 0)
//   en    - advance the phase by one, wrapping DIV_RATIO-1 -> 0
//   phase - current phase
//   tc    - terminal count, high while phase == DIV_RATIO-1
module phase_counter #(
  parameter int unsigned DIV_RATIO = 8,
  parameter int unsigned PHASE_W   = $clog2(DIV_RATIO)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [PHASE_W-1:0] phase,
  output logic               tc
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DIV_RATIO - 1);

  assign tc = (phase == PHASE_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= tc ? '0 : phase + PHASE_W'(1);
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Clock-enable and run sequencer for the pipelined core.
// Derives a one-base-cycle clkEn strobe every DIV_RATIO base cycles, holds
// coreRst for RST_HOLD core cycles after start, counts core cycles in RUN
// and optionally stops after MAX_CYCLES core cycles (0 = unlimited).
// Ports:
//   clkBase - base (fast) clock
//   rst     - synchronous active-high reset, overrides everything
//   start   - begin the sequence (sampled in IDLE only)
//   pause   - freeze phase and mask clkEn (HOLD and RUN)
//   clkEn   - core-cycle strobe (combinational decode)
//   phase   - position within the core cycle
//   coreRst - reset to the downstream core
//   cycle   - completed core cycles in RUN
//   running - high in RUN
//   done    - run limit reached, sticky until rst
module cycle_sequencer
  import cycle_seq_pkg::*;
#(
  parameter int unsigned DIV_RATIO  = 8,
  parameter int unsigned RST_HOLD   = 2,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned MAX_CYCLES = 0,
  parameter int unsigned PHASE_W    = $clog2(DIV_RATIO)
) (
  input  logic               clkBase,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  output logic               clkEn,
  output logic [PHASE_W-1:0] phase,
  output logic               coreRst,
  output logic [CYC_W-1:0]   cycle,
  output logic               running,
  output logic               done
);

  localparam int unsigned       HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam bit                LIMIT_EN  = (MAX_CYCLES != 0);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(MAX_CYCLES - 1);
  localparam logic [CYC_W-1:0]  CYC_MAX   = CYC_W'(MAX_CYCLES);

  if (!div_ratio_ok(DIV_RATIO)) begin : g_bad_div_ratio
    $error("cycle_sequencer: DIV_RATIO must be >= 2");
  end
  if (!rst_hold_ok(RST_HOLD)) begin : g_bad_rst_hold
    $error("cycle_sequencer: RST_HOLD must be >= 1");
  end
  if (!max_cycles_ok(CYC_W, 64'(MAX_CYCLES))) begin : g_bad_max_cycles
    $error("cycle_sequencer: MAX_CYCLES must be < 2**CYC_W");
  end

  seq_state_t        state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [CYC_W-1:0]  cycle_next;
  logic              core_rst_next;
  logic              done_next;
  logic              phase_en;
  logic              phase_clr;
  logic              phase_tc;

  // Phase only moves in HOLD/RUN; IDLE pins it at 0 so HOLD starts at 0,
  // DONE neither clears nor advances it, which freezes it.
  assign phase_en  = ((state == HOLD) || (state == RUN)) && !pause;
  assign phase_clr = (state == IDLE);
  assign clkEn     = phase_tc && phase_en;
  assign running   = (state == RUN);

  phase_counter #(
    .DIV_RATIO(DIV_RATIO),
    .PHASE_W  (PHASE_W)
  ) u_phase (
    .clk  (clkBase),
    .rst  (rst),
    .clr  (phase_clr),
    .en   (phase_en),
    .phase(phase),
    .tc   (phase_tc)
  );

  always_ff @(posedge clkBase) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      cycle    <= '0;
      coreRst  <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      cycle    <= cycle_next;
      coreRst  <= core_rst_next;
      done     <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    hold_next     = hold_cnt;
    cycle_next    = cycle;
    core_rst_next = coreRst;
    done_next     = done;
    unique case (state)
      IDLE: begin
        if (start) state_next = HOLD;
      end
      HOLD: begin
        if (clkEn) begin
          hold_next = hold_cnt + HOLD_W'(1);
          if (hold_cnt == HOLD_LAST) begin
            core_rst_next = 1'b0;
            state_next    = RUN;
          end
        end
      end
      RUN: begin
        if (clkEn) begin
          if (LIMIT_EN && (cycle == CYC_LAST)) begin
            cycle_next = CYC_MAX;
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            cycle_next = cycle + CYC_W'(1);
          end
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: a vector table drives the main
// instance (DIV_RATIO=8, RST_HOLD=2, MAX_CYCLES=100) and a short hand
// sequence exercises counter wrap on a narrow, unlimited instance.
module tb_cycle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        rst = 1'b1, start = 1'b0, pause = 1'b0;
  logic        clk_en, core_rst, running, done;
  logic [2:0]  phase;
  logic [31:0] cycle;

  cycle_sequencer #(
    .DIV_RATIO (8),
    .RST_HOLD  (2),
    .CYC_W     (32),
    .MAX_CYCLES(100)
  ) dut (
    .clkBase(clk),
    .rst    (rst),
    .start  (start),
    .pause  (pause),
    .clkEn  (clk_en),
    .phase  (phase),
    .coreRst(core_rst),
    .cycle  (cycle),
    .running(running),
    .done   (done)
  );

  // Narrow wrap instance
  logic       b_rst = 1'b1, b_start = 1'b0, b_pause = 1'b0;
  logic       b_clk_en, b_core_rst, b_running, b_done;
  logic [1:0] b_phase;
  logic [3:0] b_cycle;

  cycle_sequencer #(
    .DIV_RATIO (4),
    .RST_HOLD  (1),
    .CYC_W     (4),
    .MAX_CYCLES(0)
  ) dut_b (
    .clkBase(clk),
    .rst    (b_rst),
    .start  (b_start),
    .pause  (b_pause),
    .clkEn  (b_clk_en),
    .phase  (b_phase),
    .coreRst(b_core_rst),
    .cycle  (b_cycle),
    .running(b_running),
    .done   (b_done)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // steps: rising edges to advance with the inputs applied, then sample.
  typedef struct {
    int unsigned steps;
    bit          r, s, p;
    bit          ce;
    int unsigned ph;
    bit          crst, run, dn;
    int unsigned cyc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(int unsigned steps, bit r, bit s, bit p, bit ce,
                             int unsigned ph, bit crst, bit run, bit dn, int unsigned cyc);
    vec_t x;
    x.steps = steps; x.r = r; x.s = s; x.p = p; x.ce = ce; x.ph = ph;
    x.crst = crst; x.run = run; x.dn = dn; x.cyc = cyc;
    return x;
  endfunction

  task automatic push_startup();
    //                st r s p  ce ph crst run dn cyc
    vecs.push_back(v(1, 0, 1, 0, 0, 0, 1, 0, 0, 0));   // E: enter HOLD
    vecs.push_back(v(7, 0, 0, 0, 1, 7, 1, 0, 0, 0));   // E+7 first strobe
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));   // E+8
    vecs.push_back(v(7, 0, 0, 0, 1, 7, 1, 0, 0, 0));   // E+15
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));   // E+16 RUN
    vecs.push_back(v(7, 0, 0, 0, 1, 7, 0, 1, 0, 0));   // E+23
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 1));   // E+24 cycle=1
  endtask

  logic [63:0] act_v, exp_v;

  initial begin
    vecs.push_back(v(3, 1, 0, 0, 0, 0, 1, 0, 0, 0));   // reset state
    push_startup();
    // pause 5 cycles at phase 3
    vecs.push_back(v(3, 0, 0, 0, 0, 3, 0, 1, 0, 1));
    vecs.push_back(v(5, 0, 0, 1, 0, 3, 0, 1, 0, 1));
    vecs.push_back(v(4, 0, 0, 0, 1, 7, 0, 1, 0, 1));   // strobe 5 late
    // pause on phase 7: suppressed, then re-issued
    vecs.push_back(v(0, 0, 0, 1, 0, 7, 0, 1, 0, 1));
    vecs.push_back(v(2, 0, 0, 1, 0, 7, 0, 1, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 1, 7, 0, 1, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    // start held in RUN: no restart
    vecs.push_back(v(8, 0, 1, 0, 0, 0, 0, 1, 0, 3));
    vecs.push_back(v(312, 0, 0, 0, 0, 0, 0, 1, 0, 42));
    // rst mid-RUN, then rst together with start
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(3, 0, 0, 0, 0, 0, 1, 0, 0, 0));   // still IDLE
    push_startup();                                     // replay timing
    // limit: done 800 base cycles after entering RUN at E'+16
    vecs.push_back(v(791, 0, 0, 0, 1, 7, 0, 1, 0, 99));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, 100));
    vecs.push_back(v(20, 0, 1, 0, 0, 0, 0, 0, 1, 100));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 100));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));   // rst clears done

    for (int i = 0; i < vecs.size(); i++) begin
      rst   = vecs[i].r;
      start = vecs[i].s;
      pause = vecs[i].p;
      repeat (vecs[i].steps) @(posedge clk);
      #1;
      act_v = {25'd0, clk_en, phase, core_rst, running, done, cycle};
      exp_v = {25'd0, vecs[i].ce, 3'(vecs[i].ph), vecs[i].crst, vecs[i].run,
               vecs[i].dn, vecs[i].cyc};
      check($sformatf("vec%0d", i), act_v, exp_v);
    end

    // Narrow instance: DIV_RATIO=4, RST_HOLD=1, CYC_W=4, unlimited
    check("b_reset", {b_clk_en, b_phase, b_core_rst, b_running, b_done, b_cycle},
          {1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    @(negedge clk);
    b_rst   = 1'b0;
    b_start = 1'b1;
    @(posedge clk); #1;                                  // edge E
    b_start = 1'b0;
    check("b_hold", {b_clk_en, b_phase, b_core_rst, b_running, b_done, b_cycle},
          {1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    repeat (4) @(posedge clk); #1;                       // E+4
    check("b_run", {b_clk_en, b_phase, b_core_rst, b_running, b_done, b_cycle},
          {1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0});
    repeat (63) @(posedge clk); #1;                      // E+67, 16th strobe
    check("b_pre_wrap", {b_clk_en, b_phase, b_core_rst, b_running, b_done, b_cycle},
          {1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 4'd15});
    @(posedge clk); #1;
    check("b_wrap", {b_clk_en, b_phase, b_core_rst, b_running, b_done, b_cycle},
          {1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0});
    repeat (4) @(posedge clk); #1;
    check("b_post_wrap", {b_clk_en, b_phase, b_core_rst, b_running, b_done, b_cycle},
          {1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Synthesizable clock-enable and run sequencer for the pipelined processor. It replaces the hard-wired 4x-clock divide, reset release and cycle counting that the simulation top performs with a parametrised block. From the fast base clock it derives a one-base-cycle `clkEn` strobe at 1/DIV_RATIO rate. It stretches the core reset over a programmable number of divided cycles, counts completed divided (core) cycles, and optionally stops after a fixed run length.

## Interface
Parameters:
- DIV_RATIO, 8: base cycles per core cycle; must be ≥2.
- RST_HOLD, 2: core cycles that `coreRst` stays high after start; must be ≥1.
- CYC_W, 32: width of the cycle counter.
- MAX_CYCLES, 0: run length in core cycles. 0 means unlimited. Must be < 2^CYC_W.
- PHASE_W, $clog2(DIV_RATIO): phase width (derived).

Ports:
- clkBase  in  1  base (fast) clock; every flop is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin the sequence; sampled only in IDLE.
- pause  in  1  freezes the phase and masks `clkEn` in the same cycle; honoured in HOLD and RUN.
- clkEn  out  1  core-cycle strobe, high for one base cycle.
- phase  out  PHASE_W  position within the core cycle, 0..DIV_RATIO-1.
- coreRst  out  1  active-high reset to the downstream core.
- cycle  out  CYC_W  number of completed core cycles in RUN.
- running  out  1  high in the RUN state.
- done  out  1  run limit reached; sticky until `rst`.

## Operation
- States are IDLE, HOLD, RUN and DONE.
- Reset values, applied on the edge where `rst`=1: state=IDLE, phase=0, holdCnt=0, cycle=0, coreRst=1, running=0, done=0, clkEn=0. `rst` overrides every other input in every state, including mid-RUN.
- IDLE:
  - phase is held at 0 and clkEn=0.
  - When start=1, go to HOLD with phase=0. A one-cycle `start` pulse is sufficient.
- HOLD:
  - phase increments modulo DIV_RATIO unless pause=1.
  - clkEn = (phase==DIV_RATIO-1) && !pause.
  - holdCnt increments on each clkEn.
  - On the clkEn where holdCnt==RST_HOLD-1: coreRst←0, state←RUN, phase wraps to 0.
- RUN:
  - phase and clkEn behave as in HOLD.
  - Each clkEn increments `cycle`. When MAX_CYCLES=0 the counter wraps 2^CYC_W-1 → 0 silently.
  - When MAX_CYCLES≠0, the clkEn with cycle==MAX_CYCLES-1 performs cycle←MAX_CYCLES, done←1, state←DONE.
  - `start` is ignored.
- DONE:
  - clkEn=0 and phase is frozen.
  - cycle holds MAX_CYCLES and coreRst stays 0.
  - The block leaves DONE only via `rst`.
- clkEn is a combinational decode of registered state, registered phase and the `pause` input. All other outputs are registered.
- running = (state==RUN).

## Timing
- Let E be the edge at which start=1 is seen in IDLE.
- HOLD begins after E with phase=0.
- The first clkEn occurs in base cycle E+DIV_RATIO-1, counting cycles after E from 0.
- coreRst falls at edge E+DIV_RATIO·RST_HOLD.
- The first RUN clkEn occurs DIV_RATIO-1 cycles later. `cycle` reads 1 after the following edge.
- With no pause, clkEn is periodic with period DIV_RATIO and duty 1/DIV_RATIO.
- Each pause cycle delays every later event by exactly one base cycle. If pause=1 while phase==DIV_RATIO-1, that strobe is suppressed and is re-issued on the first cycle with pause=0.
- rst and start in the same cycle: rst wins and the state stays IDLE.
- Reaching the limit on the same edge as pause=1 cannot happen, because the limit only fires on an unmasked clkEn.

## Structure
- Package `cycle_seq_pkg` holds the state enum (IDLE, HOLD, RUN, DONE) and the legal-parameter check functions.
- Sub-module `phase_counter` is a mod-DIV_RATIO counter with enable, synchronous clear and a terminal-count output. The top level contains the FSM, holdCnt, the cycle counter and the limit compare.

## Test plan
- DIV_RATIO=8, RST_HOLD=2, rst for 3 cycles, start at E → clkEn at E+7 and E+15; coreRst=0 from E+16; running=1; first RUN clkEn at E+23; cycle=1 after E+24.
- MAX_CYCLES=100, DIV_RATIO=8 → done=1 exactly 800 base cycles after entering RUN; cycle=100; no further clkEn; phase frozen.
- pause=1 for 5 cycles while phase=3 → phase holds at 3; the next clkEn is delayed by 5 cycles; a pause on phase=7 suppresses and then re-issues the strobe.
- rst pulse mid-RUN at cycle=42 → the next edge gives cycle=0, coreRst=1, running=0, phase=0, state IDLE. A new start replays scenario 1 timing.
- CYC_W=4, MAX_CYCLES=0 → cycle goes 15→0 on the 16th clkEn; done stays 0; running stays 1.
- start held high through RUN, plus start asserted together with rst → no re-entry to HOLD and no restart; with rst, the state stays IDLE.
